// File: rtl/target_scheduler.sv
// Picks the live scoring target for the ten-number obstacle row. Targets stay live for a bounded
// number of frames, accept one hit, report an award or a miss, then cool down.
module target_scheduler #(
  parameter int         TARGET_FRAMES   = 180,
  parameter int         COOLDOWN_FRAMES = 30,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic       hit,
  output logic [3:0] scoreNumber,
  output logic       targetActive,
  output logic       scorePulse,
  output logic [4:0] scoreValue,
  output logic       missPulse,
  output logic [3:0] streak
);

  localparam int FMAX = (TARGET_FRAMES > COOLDOWN_FRAMES) ? TARGET_FRAMES : COOLDOWN_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam logic [FW-1:0] TLAST = FW'(TARGET_FRAMES - 1);
  localparam logic [FW-1:0] CLAST = FW'(COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} stateT;

  stateT         state;
  logic [FW-1:0] fcnt;
  logic [7:0]    lfsr;
  logic [3:0]    nib, folded, pick;
  logic [4:0]    award;

  // Fold the nibble into 0-9 and never repeat the target currently shown.
  always_comb begin
    nib    = lfsr[3:0];
    folded = (nib >= 4'd10) ? nib - 4'd10 : nib;
    pick   = folded;
    if (folded == scoreNumber) pick = (folded == 4'd9) ? 4'd0 : folded + 4'd1;
    award  = {1'b0, scoreNumber} + {1'b0, streak};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      fcnt         <= '0;
      lfsr         <= LFSR_SEED;
      scoreNumber  <= 4'd0;
      targetActive <= 1'b0;
      scorePulse   <= 1'b0;
      scoreValue   <= 5'd0;
      missPulse    <= 1'b0;
      streak       <= 4'd0;
    end else begin
      scorePulse <= 1'b0;
      missPulse  <= 1'b0;
      scoreValue <= 5'd0;
      // The LFSR free-runs on frames regardless of state; `pick` sees the pre-step value.
      if (startOfFrame) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (!enable) begin
        state        <= IDLE;
        fcnt         <= '0;
        targetActive <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (startOfFrame) begin
              scoreNumber  <= pick;
              fcnt         <= '0;
              targetActive <= 1'b1;
              state        <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (hit) begin
              scorePulse   <= 1'b1;
              scoreValue   <= award;
              streak       <= (streak == 4'd15) ? 4'd15 : streak + 4'd1;
              fcnt         <= '0;
              targetActive <= 1'b0;
              state        <= COOLDOWN;
            end else if (startOfFrame) begin
              if (fcnt == TLAST) begin
                missPulse    <= 1'b1;
                streak       <= 4'd0;
                fcnt         <= '0;
                targetActive <= 1'b0;
                state        <= COOLDOWN;
              end else begin
                fcnt <= fcnt + 1'b1;
              end
            end
          end
          COOLDOWN: begin
            if (startOfFrame) begin
              if (fcnt == CLAST) begin
                scoreNumber  <= pick;
                fcnt         <= '0;
                targetActive <= 1'b1;
                state        <= ACTIVE;
              end else begin
                fcnt <= fcnt + 1'b1;
              end
            end
          end
          default: begin
            state        <= IDLE;
            fcnt         <= '0;
            targetActive <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
